// File: rtl/processor_trace_buffer.sv
// -----------------------------------------------------------------------------
// processor_trace_buffer
//
// Capture buffer on the observation side of the processor. Once armed it waits
// for a trigger (immediate, or ALU result equal to a compare value). From the
// trigger edge onward it stores DEPTH consecutive {ALU_Out, MEM_Out} samples,
// one per clock. It then hands them out oldest first over a show-ahead
// valid/ready read port. When the last sample is read, the block returns to
// IDLE.
//
// Parameters
//   DEPTH       samples per capture window (power of two, 2..256)
//   ADDR_W      log2(DEPTH)
//
// Ports
//   Clk         clock, all state updates on the rising edge
//   Rst         asynchronous active-high reset
//   ALU_Out     processor ALU result, sampled directly
//   MEM_Out     processor memory read data, sampled directly
//   Arm         one-cycle capture request, honoured only in IDLE
//   Abort       synchronous return to IDLE, discards the buffer
//   Trig_En     1: trigger on ALU_Out == Trig_Value, 0: trigger at once
//   Trig_Value  trigger compare value (exact 32-bit match)
//   Rd_Ready    reader accepts Rd_Data this cycle
//   Rd_Valid    Rd_Data holds an unread sample (DONE only)
//   Rd_Data     {ALU sample, MEM sample} at the read pointer
//   State       00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE
//   Count       number of samples currently stored
//   Trig_Delay  ARMED edges before the trigger, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module processor_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [31:0]       ALU_Out,
    input  logic [31:0]       MEM_Out,
    input  logic              Arm,
    input  logic              Abort,
    input  logic              Trig_En,
    input  logic [31:0]       Trig_Value,
    input  logic              Rd_Ready,
    output logic              Rd_Valid,
    output logic [63:0]       Rd_Data,
    output logic [1:0]        State,
    output logic [ADDR_W:0]   Count,
    output logic [15:0]       Trig_Delay
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ARMED   = 2'b01;
    localparam logic [1:0] ST_CAPTURE = 2'b10;
    localparam logic [1:0] ST_DONE    = 2'b11;

    localparam logic [ADDR_W-1:0] PTR_ZERO   = '0;
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO   = '0;
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    // Count value held while the final sample of the window is being written.
    localparam logic [ADDR_W:0]   CNT_LAST_W = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [15:0]       DELAY_MAX  = 16'hFFFF;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] wp_q,         wp_d;
    logic [ADDR_W-1:0] rp_q,         rp_d;
    logic [ADDR_W:0]   count_q,      count_d;
    logic [15:0]       trig_delay_q, trig_delay_d;

    logic [63:0]       mem_q [DEPTH];
    logic              mem_we;
    logic [63:0]       wr_data;

    logic              trig_hit;
    logic              rd_fire;

    assign wr_data  = {ALU_Out, MEM_Out};
    assign trig_hit = !Trig_En || (ALU_Out == Trig_Value);
    assign rd_fire  = (state_q == ST_DONE) && (count_q != CNT_ZERO) && Rd_Ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        wp_d         = wp_q;
        rp_d         = rp_q;
        count_d      = count_q;
        trig_delay_d = trig_delay_q;
        mem_we       = 1'b0;

        if (Abort) begin
            // Abort beats everything, including a simultaneous Arm. The trigger
            // delay of the abandoned capture is left visible.
            state_d = ST_IDLE;
            wp_d    = PTR_ZERO;
            rp_d    = PTR_ZERO;
            count_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wp_d    = PTR_ZERO;
                    rp_d    = PTR_ZERO;
                    count_d = CNT_ZERO;
                    if (Arm) begin
                        state_d      = ST_ARMED;
                        trig_delay_d = 16'd0;
                    end
                end

                ST_ARMED: begin
                    if (trig_hit) begin
                        // The trigger sample itself is the first stored sample.
                        mem_we  = 1'b1;
                        wp_d    = wp_q + PTR_ONE;
                        count_d = CNT_ONE;
                        state_d = ST_CAPTURE;
                    end else if (trig_delay_q != DELAY_MAX) begin
                        trig_delay_d = trig_delay_q + 16'd1;
                    end
                end

                ST_CAPTURE: begin
                    // One sample per edge with no stall; the reader is ignored.
                    mem_we  = 1'b1;
                    wp_d    = wp_q + PTR_ONE;
                    count_d = count_q + CNT_ONE;
                    if (count_q == CNT_LAST_W) begin
                        state_d = ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (rd_fire) begin
                        rp_d    = rp_q + PTR_ONE;
                        count_d = count_q - CNT_ONE;
                        if (count_q == CNT_ONE) begin
                            // Last sample leaves on this edge; restart clean.
                            state_d = ST_IDLE;
                            wp_d    = PTR_ZERO;
                            rp_d    = PTR_ZERO;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            wp_q         <= PTR_ZERO;
            rp_q         <= PTR_ZERO;
            count_q      <= CNT_ZERO;
            trig_delay_q <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q      <= state_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            trig_delay_q <= trig_delay_d;
        end
    end

    // -------------------------------------------------------------------------
    // Sample storage
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset. Count and the state gate every read, so
    // stale contents are never presented. Leaving it unreset also lets it map
    // onto plain RAM.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign Rd_Valid   = (state_q == ST_DONE) && (count_q != CNT_ZERO);
    assign Rd_Data    = mem_q[rp_q];
    assign State      = state_q;
    assign Count      = count_q;
    assign Trig_Delay = trig_delay_q;

endmodule
